// File: rtl/bsg_blackparrot_mem_striper.sv
// N-channel memory-command striper: picks a downstream channel from physical-address bits
// and returns responses to the core in strict command order.
// Latency: 0 cycles on both the command and response paths; the order queue and counter update on the next clk_i edge.
// Backpressure: commands stall when the order queue is full, when fence_i is high, or when the selected channel is not ready.
//               A response from a channel that is not at the head of the queue is held until that channel reaches the head.
// Ports: core side     cmd_i/cmd_addr_i/cmd_v_i/cmd_ready_and_o, resp_o/resp_v_o/resp_yumi_i
//        channel side  chan_cmd_o/chan_cmd_v_o/chan_cmd_ready_and_i, chan_resp_i/chan_resp_v_i/chan_resp_yumi_o
//        control       fence_i, outstanding_o, idle_o
module bsg_blackparrot_mem_striper #(
    parameter int num_channels_p    = 2,
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 128,
    parameter int paddr_width_p     = 40,
    parameter int stripe_lsb_p      = 6,
    parameter int max_outstanding_p = 8
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,
    input  logic [cmd_width_p-1:0]                         cmd_i,
    input  logic [paddr_width_p-1:0]                       cmd_addr_i,
    input  logic                                           cmd_v_i,
    output logic                                           cmd_ready_and_o,
    output logic [resp_width_p-1:0]                        resp_o,
    output logic                                           resp_v_o,
    input  logic                                           resp_yumi_i,
    output logic [num_channels_p-1:0][cmd_width_p-1:0]     chan_cmd_o,
    output logic [num_channels_p-1:0]                      chan_cmd_v_o,
    input  logic [num_channels_p-1:0]                      chan_cmd_ready_and_i,
    input  logic [num_channels_p-1:0][resp_width_p-1:0]    chan_resp_i,
    input  logic [num_channels_p-1:0]                      chan_resp_v_i,
    output logic [num_channels_p-1:0]                      chan_resp_yumi_o,
    input  logic                                           fence_i,
    output logic [$clog2(max_outstanding_p+1)-1:0]         outstanding_o,
    output logic                                           idle_o
);

    localparam int sel_w = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w = $clog2(max_outstanding_p + 1);

    logic [sel_w-1:0] sel;
    logic [sel_w-1:0] head;
    logic [sel_w-1:0] order_q [max_outstanding_p];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             full;
    logic             empty;
    logic             cmd_open;
    logic             acc;
    logic             pop;
    logic             unused_addr_bits;

    // Only the stripe field of the address is significant here.
    assign unused_addr_bits = ^cmd_addr_i;

    generate
        if (num_channels_p > 1) begin : g_sel_multi
            assign sel = cmd_addr_i[stripe_lsb_p +: sel_w];
        end else begin : g_sel_single
            assign sel = '0;
        end
    endgenerate

    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        // Explicit wrap, so a depth that is not a power of two still works.
        return (p == ptr_w'(max_outstanding_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // full is taken from the registered count only, so a pop in the same cycle cannot open a slot.
    assign full  = (count == cnt_w'(max_outstanding_p));
    assign empty = (count == '0);
    assign head  = order_q[rd_ptr];

    // Gating with reset_n_i holds every handshake output low while reset is asserted.
    assign cmd_open        = reset_n_i & ~full & ~fence_i;
    assign cmd_ready_and_o = cmd_open & chan_cmd_ready_and_i[sel];
    assign acc             = cmd_v_i & cmd_ready_and_o;
    assign chan_cmd_o      = {num_channels_p{cmd_i}};

    always_comb begin
        chan_cmd_v_o      = '0;
        chan_cmd_v_o[sel] = cmd_v_i & cmd_open;
    end

    assign resp_v_o = reset_n_i & ~empty & chan_resp_v_i[head];
    assign resp_o   = chan_resp_i[head];
    // A yumi without a valid response is ignored rather than allowed to corrupt the queue.
    assign pop      = resp_yumi_i & resp_v_o;

    always_comb begin
        chan_resp_yumi_o       = '0;
        chan_resp_yumi_o[head] = pop;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc) wr_ptr <= ptr_next(wr_ptr);
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({acc, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Order-queue storage does not need a reset: entries are read only while count is nonzero.
    always_ff @(posedge clk_i) begin
        if (acc) order_q[wr_ptr] <= sel;
    end

    assign outstanding_o = count;
    assign idle_o        = empty;

endmodule

// File: tb/tb_bsg_blackparrot_mem_striper.sv
module tb_bsg_blackparrot_mem_striper;

    localparam int NC = 4;
    localparam int CW = 64;
    localparam int RW = 64;
    localparam int AW = 40;
    localparam int MO = 8;
    localparam logic [63:0] RESP_XOR = 64'hA5A5_5A5A_0F0F_F0F0;

    logic                   clk = 1'b0;
    logic                   reset_n_i;
    logic [CW-1:0]          cmd_i;
    logic [AW-1:0]          cmd_addr_i;
    logic                   cmd_v_i;
    logic                   cmd_ready_and_o;
    logic [RW-1:0]          resp_o;
    logic                   resp_v_o;
    logic                   resp_yumi_i;
    logic [NC-1:0][CW-1:0]  chan_cmd_o;
    logic [NC-1:0]          chan_cmd_v_o;
    logic [NC-1:0]          chan_cmd_ready_and_i;
    logic [NC-1:0][RW-1:0]  chan_resp_i;
    logic [NC-1:0]          chan_resp_v_i;
    logic [NC-1:0]          chan_resp_yumi_o;
    logic                   fence_i;
    logic [3:0]             outstanding_o;
    logic                   idle_o;

    bsg_blackparrot_mem_striper #(
        .num_channels_p(NC), .cmd_width_p(CW), .resp_width_p(RW),
        .paddr_width_p(AW), .stripe_lsb_p(6), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .cmd_i(cmd_i), .cmd_addr_i(cmd_addr_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .resp_o(resp_o),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .chan_cmd_o(chan_cmd_o),
        .chan_cmd_v_o(chan_cmd_v_o), .chan_cmd_ready_and_i(chan_cmd_ready_and_i),
        .chan_resp_i(chan_resp_i), .chan_resp_v_i(chan_resp_v_i),
        .chan_resp_yumi_o(chan_resp_yumi_o), .fence_i(fence_i),
        .outstanding_o(outstanding_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [63:0] dat;
    } ent_t;

    ent_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] resp_en  = '0;
    bit         yumi_en  = 1'b0;
    bit         last_acc = 1'b0;
    int         issued;
    logic [63:0] dat_a;
    logic [63:0] dat_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sel_of(input logic [AW-1:0] a);
        return a[7:6];
    endfunction

    // Channel model: each channel offers the response to its oldest outstanding command when enabled.
    task automatic settle();
        chan_resp_v_i = '0;
        chan_resp_i   = '0;
        resp_yumi_i   = 1'b0;
        for (int c = 0; c < NC; c++) begin
            bit found = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (!found && exp_q[i].ch == 2'(c)) begin
                    found          = 1'b1;
                    chan_resp_i[c] = exp_q[i].dat ^ RESP_XOR;
                    chan_resp_v_i[c] = resp_en[c];
                end
            end
        end
        #1;
    endtask

    task automatic commit();
        logic [3:0] exp_v;
        logic       exp_rdy;
        logic       exp_resp_v;
        exp_v   = '0;
        exp_rdy = (exp_q.size() < MO) && !fence_i && chan_cmd_ready_and_i[sel_of(cmd_addr_i)];
        if (cmd_v_i && exp_q.size() < MO && !fence_i) exp_v[sel_of(cmd_addr_i)] = 1'b1;
        exp_resp_v = (exp_q.size() != 0) && resp_en[exp_q[0].ch];
        check("cmd_ready", 64'(cmd_ready_and_o), 64'(exp_rdy));
        check("chan_cmd_v", 64'(chan_cmd_v_o), 64'(exp_v));
        check("resp_v", 64'(resp_v_o), 64'(exp_resp_v));
        last_acc = cmd_v_i && cmd_ready_and_o;
        if (yumi_en && resp_v_o) resp_yumi_i = 1'b1;
        #1;
        if (resp_yumi_i) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(resp_yumi_i), 64'(0));
            end else begin
                check("resp_dat", resp_o, exp_q[0].dat ^ RESP_XOR);
                check("resp_yumi_chan", 64'(chan_resp_yumi_o), 64'(4'b0001 << exp_q[0].ch));
                void'(exp_q.pop_front());
            end
        end else begin
            check("resp_yumi_idle", 64'(chan_resp_yumi_o), 64'(0));
        end
        if (last_acc) begin
            ent_t e;
            e.ch  = sel_of(cmd_addr_i);
            e.dat = cmd_i;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("outstanding", 64'(outstanding_o), 64'(exp_q.size()));
        check("idle", 64'(idle_o), 64'(exp_q.size() == 0));
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        commit();
    endtask

    task automatic drain();
        cmd_v_i = 1'b0;
        resp_en = '1;
        yumi_en = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        reset_n_i = 1'b0;
        cmd_i = '0;
        cmd_addr_i = '0;
        cmd_v_i = 1'b0;
        resp_yumi_i = 1'b0;
        chan_cmd_ready_and_i = '1;
        chan_resp_i = '0;
        chan_resp_v_i = '0;
        fence_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_idle", 64'(idle_o), 64'(1));
        check("rst_resp_v", 64'(resp_v_o), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready_and_o), 64'(1));
        @(negedge clk);

        // Ordering: ch1 answers first but must wait behind ch0.
        dat_a = 64'h1111_2222_3333_4444;
        dat_b = 64'h5555_6666_7777_8888;
        resp_en = '0;
        yumi_en = 1'b1;
        cmd_v_i = 1'b1;
        cmd_addr_i = 40'h000;
        cmd_i = dat_a;
        step();
        cmd_addr_i = 40'h040;
        cmd_i = dat_b;
        settle();
        check("ord_chan_v", 64'(chan_cmd_v_o), 64'(4'b0010));
        check("ord_chan_cmd1", chan_cmd_o[1], dat_b);
        check("ord_chan_cmd3", chan_cmd_o[3], dat_b);
        commit();
        cmd_v_i = 1'b0;
        resp_en = 4'b0010;
        repeat (2) begin
            settle();
            check("ord_hold", 64'(resp_v_o), 64'(0));
            commit();
        end
        resp_en = 4'b0011;
        settle();
        check("ord_first_v", 64'(resp_v_o), 64'(1));
        check("ord_first_dat", resp_o, dat_a ^ RESP_XOR);
        commit();
        settle();
        check("ord_second_dat", resp_o, dat_b ^ RESP_XOR);
        commit();
        check("ord_done", 64'(exp_q.size()), 64'(0));

        // Backpressure on the selected channel only.
        resp_en = '0;
        chan_cmd_ready_and_i = 4'b1110;
        cmd_v_i = 1'b1;
        cmd_addr_i = 40'h000;
        cmd_i = 64'hDEAD_0000;
        settle();
        check("bp_ready0", 64'(cmd_ready_and_o), 64'(0));
        check("bp_chan_v0", 64'(chan_cmd_v_o), 64'(4'b0001));
        commit();
        cmd_addr_i = 40'h040;
        cmd_i = 64'hDEAD_0040;
        settle();
        check("bp_ready1", 64'(cmd_ready_and_o), 64'(1));
        check("bp_chan_v1", 64'(chan_cmd_v_o), 64'(4'b0010));
        commit();
        chan_cmd_ready_and_i = '1;
        drain();

        // Full boundary: eight accepted, ninth blocked even while a pop happens.
        resp_en = '0;
        cmd_v_i = 1'b1;
        for (int i = 0; i < MO; i++) begin
            cmd_addr_i = 40'(i) << 6;
            cmd_i = {$urandom(), $urandom()};
            step();
        end
        check("full_count", 64'(outstanding_o), 64'(MO));
        cmd_addr_i = 40'h0C0;
        cmd_i = 64'hF0F0_1234;
        resp_en = '1;
        settle();
        check("full_ready", 64'(cmd_ready_and_o), 64'(0));
        check("full_pop_v", 64'(resp_v_o), 64'(1));
        commit();
        resp_en = '0;
        settle();
        check("full_reopen", 64'(cmd_ready_and_o), 64'(1));
        commit();
        check("full_refill", 64'(outstanding_o), 64'(MO));
        drain();

        // Fence with three in flight.
        resp_en = '0;
        cmd_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_addr_i = 40'(i) << 6;
            cmd_i = {$urandom(), $urandom()};
            step();
        end
        fence_i = 1'b1;
        settle();
        check("fence_ready", 64'(cmd_ready_and_o), 64'(0));
        check("fence_chan_v", 64'(chan_cmd_v_o), 64'(0));
        check("fence_busy", 64'(idle_o), 64'(0));
        commit();
        resp_en = '1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("fence_idle", 64'(idle_o), 64'(1));
        check("fence_count", 64'(outstanding_o), 64'(0));
        fence_i = 1'b0;
        cmd_v_i = 1'b0;

        // Random traffic across four channels; wraps the queue pointers.
        issued = 0;
        for (int cyc = 0; cyc < 2000 && (issued < 20 || exp_q.size() != 0); cyc++) begin
            cmd_v_i = (issued < 20) && ($urandom_range(0, 3) != 0);
            cmd_addr_i = 40'({$urandom(), $urandom()});
            cmd_i = {$urandom(), $urandom()};
            chan_cmd_ready_and_i = 4'($urandom());
            resp_en = 4'($urandom());
            yumi_en = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) issued++;
        end
        check("rand_issued", 64'(issued), 64'(20));
        check("rand_final_count", 64'(outstanding_o), 64'(0));
        check("rand_final_idle", 64'(idle_o), 64'(1));

        // Reset with five in flight.
        cmd_v_i = 1'b1;
        chan_cmd_ready_and_i = '1;
        resp_en = '0;
        for (int i = 0; i < 5; i++) begin
            cmd_addr_i = 40'(i) << 6;
            cmd_i = {$urandom(), $urandom()};
            step();
        end
        check("pre_rst_count", 64'(outstanding_o), 64'(5));
        reset_n_i = 1'b0;
        chan_resp_v_i = '1;
        resp_yumi_i = 1'b0;
        #1;
        check("in_rst_ready", 64'(cmd_ready_and_o), 64'(0));
        check("in_rst_chan_v", 64'(chan_cmd_v_o), 64'(0));
        check("in_rst_resp_v", 64'(resp_v_o), 64'(0));
        check("in_rst_yumi", 64'(chan_resp_yumi_o), 64'(0));
        @(posedge clk);
        #1;
        check("post_rst_count", 64'(outstanding_o), 64'(0));
        check("post_rst_idle", 64'(idle_o), 64'(1));
        exp_q.delete();
        @(negedge clk);
        reset_n_i = 1'b1;
        cmd_v_i = 1'b0;
        chan_resp_v_i = '1;
        #1;
        check("post_rst_resp_v", 64'(resp_v_o), 64'(0));
        check("post_rst_yumi", 64'(chan_resp_yumi_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
